// File: rtl/phy_tx_link_ctrl.sv
// Two-lane PHY transmit link sequencer: COM alignment, FWFT lane drain,
// periodic COM re-sync, idle fill and clean shutdown.
module phy_tx_link_ctrl #(
    parameter int unsigned SYNC_CYCLES   = 4,
    parameter int unsigned RESYNC_PERIOD = 64,
    parameter int unsigned DRAIN_MAX     = 16,
    parameter logic [7:0]  COM_SYM       = 8'hBC,
    parameter logic [7:0]  IDL_SYM       = 8'h7C
) (
    input  logic       clk_2f,
    input  logic       reset,
    input  logic       start,
    input  logic       fifo_empty_0,
    input  logic [7:0] fifo_data_0,
    input  logic       fifo_empty_1,
    input  logic [7:0] fifo_data_1,
    output logic       pop_0,
    output logic       pop_1,
    output logic [7:0] data_out_0,
    output logic       valid_out_0,
    output logic [7:0] data_out_1,
    output logic       valid_out_1,
    output logic       phy_enable,
    output logic       link_up,
    output logic [1:0] state_out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SYNC   = 2'd1,
        S_ACTIVE = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    localparam bit RESYNC_EN = (RESYNC_PERIOD != 0);
    localparam int SW = $clog2(SYNC_CYCLES + 1);
    localparam int RW = RESYNC_EN ? $clog2(RESYNC_PERIOD + 1) : 1;
    localparam int DW = $clog2(DRAIN_MAX + 1);

    localparam logic [SW-1:0] SYNC_LAST   = SW'(SYNC_CYCLES - 1);
    localparam logic [RW-1:0] RESYNC_LAST =
        RW'(RESYNC_EN ? RESYNC_PERIOD - 1 : 0);
    localparam logic [DW-1:0] DRAIN_LAST  = DW'(DRAIN_MAX - 1);

    state_t        state;
    logic [SW-1:0] sync_cnt;
    logic [RW-1:0] resync_cnt;
    logic [DW-1:0] drain_cnt;

    logic       resync_slot;
    logic       lane_ok;
    logic [7:0] lane_d0;
    logic [7:0] lane_d1;

    assign resync_slot = RESYNC_EN && (state == S_ACTIVE) &&
                         (resync_cnt == RESYNC_LAST);

    // Lanes drain in ACTIVE (outside COM slots) and DRAIN only.
    assign lane_ok = !reset &&
                     (((state == S_ACTIVE) && !resync_slot) ||
                      (state == S_DRAIN));

    assign pop_0 = lane_ok && !fifo_empty_0;
    assign pop_1 = lane_ok && !fifo_empty_1;

    assign lane_d0 = pop_0 ? fifo_data_0 : IDL_SYM;
    assign lane_d1 = pop_1 ? fifo_data_1 : IDL_SYM;

    assign state_out = state;

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            sync_cnt    <= '0;
            resync_cnt  <= '0;
            drain_cnt   <= '0;
            data_out_0  <= 8'h00;
            valid_out_0 <= 1'b0;
            data_out_1  <= 8'h00;
            valid_out_1 <= 1'b0;
            phy_enable  <= 1'b0;
            link_up     <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    data_out_0  <= IDL_SYM;
                    valid_out_0 <= 1'b0;
                    data_out_1  <= IDL_SYM;
                    valid_out_1 <= 1'b0;
                    link_up     <= 1'b0;
                    phy_enable  <= start;
                    if (start) begin
                        state    <= S_SYNC;
                        sync_cnt <= '0;
                    end
                end
                S_SYNC: begin
                    data_out_0  <= COM_SYM;
                    valid_out_0 <= 1'b1;
                    data_out_1  <= COM_SYM;
                    valid_out_1 <= 1'b1;
                    if (!start) begin
                        state      <= S_IDLE;
                        phy_enable <= 1'b0;
                        link_up    <= 1'b0;
                    end else if (sync_cnt == SYNC_LAST) begin
                        state      <= S_ACTIVE;
                        resync_cnt <= '0;
                        phy_enable <= 1'b1;
                        link_up    <= 1'b1;
                    end else begin
                        sync_cnt   <= sync_cnt + 1'b1;
                        phy_enable <= 1'b1;
                        link_up    <= 1'b0;
                    end
                end
                S_ACTIVE: begin
                    if (resync_slot) begin
                        data_out_0  <= COM_SYM;
                        valid_out_0 <= 1'b1;
                        data_out_1  <= COM_SYM;
                        valid_out_1 <= 1'b1;
                        resync_cnt  <= '0;
                    end else begin
                        data_out_0  <= lane_d0;
                        valid_out_0 <= pop_0;
                        data_out_1  <= lane_d1;
                        valid_out_1 <= pop_1;
                        if (RESYNC_EN) begin
                            resync_cnt <= resync_cnt + 1'b1;
                        end
                    end
                    phy_enable <= 1'b1;
                    if (!start) begin
                        state     <= S_DRAIN;
                        drain_cnt <= '0;
                        link_up   <= 1'b0;
                    end else begin
                        link_up   <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    data_out_0  <= lane_d0;
                    valid_out_0 <= pop_0;
                    data_out_1  <= lane_d1;
                    valid_out_1 <= pop_1;
                    link_up     <= 1'b0;
                    // Leave on empty lanes or when the drain budget runs out.
                    if ((fifo_empty_0 && fifo_empty_1) ||
                        (drain_cnt == DRAIN_LAST)) begin
                        state      <= S_IDLE;
                        phy_enable <= 1'b0;
                    end else begin
                        drain_cnt  <= drain_cnt + 1'b1;
                        phy_enable <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
